// File: rtl/iob2axi_burst.sv
// Native valid/ready slave to AXI4 master bridge: one INCR burst per run pulse.
// A control port starts the burst; data beats then move one per native handshake.
module iob2axi_burst #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int AXI_ID_W  = 1,
    parameter int AXI_LEN_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic                  direction,
    input  logic [AXI_LEN_W-1:0]  length,
    output logic                  ready,
    output logic                  error,
    input  logic                  s_valid,
    input  logic [ADDR_W-1:0]     s_addr,
    input  logic [DATA_W-1:0]     s_wdata,
    input  logic [DATA_W/8-1:0]   s_wstrb,
    output logic [DATA_W-1:0]     s_rdata,
    output logic                  s_ready,
    output logic [AXI_ID_W-1:0]   m_axi_awid,
    output logic [ADDR_W-1:0]     m_axi_awaddr,
    output logic [AXI_LEN_W-1:0]  m_axi_awlen,
    output logic [2:0]            m_axi_awsize,
    output logic [1:0]            m_axi_awburst,
    output logic                  m_axi_awlock,
    output logic [3:0]            m_axi_awcache,
    output logic [2:0]            m_axi_awprot,
    output logic [3:0]            m_axi_awqos,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [DATA_W-1:0]     m_axi_wdata,
    output logic [DATA_W/8-1:0]   m_axi_wstrb,
    output logic                  m_axi_wlast,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [AXI_ID_W-1:0]   m_axi_bid,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [AXI_ID_W-1:0]   m_axi_arid,
    output logic [ADDR_W-1:0]     m_axi_araddr,
    output logic [AXI_LEN_W-1:0]  m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arlock,
    output logic [3:0]            m_axi_arcache,
    output logic [2:0]            m_axi_arprot,
    output logic [3:0]            m_axi_arqos,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [AXI_ID_W-1:0]   m_axi_rid,
    input  logic [DATA_W-1:0]     m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    output logic [1:0]            fsm_state
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t                 state_q, state_d;
    logic                   dir_q;
    logic [AXI_LEN_W-1:0]   len_q;
    logic [AXI_LEN_W-1:0]   cnt_q;
    logic [ADDR_W-1:0]      addr_q;
    logic                   w_hs, r_hs, last_beat;
    logic                   unused_ids;

    assign unused_ids = ^{m_axi_bid, m_axi_rid};

    // Every channel transfers on the clock edge where valid and ready are both 1.
    // Native side: s_ready is a registered one-cycle ack; while it is high the
    // AXI data valid/ready is masked so the held beat is never issued twice.
    assign w_hs      = m_axi_wvalid & m_axi_wready;
    assign r_hs      = m_axi_rvalid & m_axi_rready;
    assign last_beat = (cnt_q == len_q);

    assign ready     = (state_q == IDLE);
    assign fsm_state = state_q;

    assign m_axi_awid    = '0;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = len_q;
    assign m_axi_awsize  = 3'($clog2(DATA_W/8));
    assign m_axi_awburst = 2'b01;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = 4'b0011;
    assign m_axi_awprot  = 3'b010;
    assign m_axi_awqos   = 4'b0000;
    assign m_axi_awvalid = (state_q == ADDR) & dir_q;

    assign m_axi_arid    = '0;
    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = len_q;
    assign m_axi_arsize  = 3'($clog2(DATA_W/8));
    assign m_axi_arburst = 2'b01;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'b0011;
    assign m_axi_arprot  = 3'b010;
    assign m_axi_arqos   = 4'b0000;
    assign m_axi_arvalid = (state_q == ADDR) & ~dir_q;

    assign m_axi_wdata   = s_wdata;
    assign m_axi_wstrb   = s_wstrb;
    assign m_axi_wlast   = (state_q == DATA) & dir_q & last_beat;
    assign m_axi_wvalid  = (state_q == DATA) & dir_q & s_valid & ~s_ready;
    assign m_axi_rready  = (state_q == DATA) & ~dir_q & s_valid & ~s_ready;
    assign m_axi_bready  = (state_q == RESP);

    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (run) state_d = ADDR;
            ADDR: if (dir_q ? m_axi_awready : m_axi_arready) state_d = DATA;
            DATA: begin
                if (dir_q) begin
                    if (w_hs && last_beat) state_d = RESP;
                end else if (r_hs && (m_axi_rlast || last_beat)) begin
                    state_d = IDLE;
                end
            end
            RESP: if (m_axi_bvalid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            dir_q   <= 1'b0;
            len_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            error   <= 1'b0;
            s_ready <= 1'b0;
            s_rdata <= '0;
        end else begin
            s_ready <= 1'b0;
            if (state_q == IDLE && run) begin
                dir_q  <= direction;
                len_q  <= length;
                addr_q <= s_addr;
                cnt_q  <= '0;
                error  <= 1'b0;
            end
            if (w_hs) begin
                cnt_q   <= cnt_q + 1'b1;
                s_ready <= 1'b1;
            end
            if (r_hs) begin
                cnt_q   <= cnt_q + 1'b1;
                s_ready <= 1'b1;
                s_rdata <= m_axi_rdata;
                if (m_axi_rresp != 2'b00) error <= 1'b1;
            end
            if (state_q == RESP && m_axi_bvalid) error <= (m_axi_bresp != 2'b00);
        end
    end

endmodule

// File: tb/tb_iob2axi_burst.sv
// Bench for iob2axi_burst: AXI RAM slave with random stalls, directed bursts,
// expected-queue scoreboard checked by a negedge monitor.
module tb_iob2axi_burst;

    localparam int AW = 24;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic run = 1'b0, direction = 1'b0, s_valid = 1'b0;
    logic [7:0] length = '0;
    logic [AW-1:0] s_addr = '0;
    logic [DW-1:0] s_wdata = '0;
    logic [3:0] s_wstrb = '0;
    logic ready, error, s_ready;
    logic [DW-1:0] s_rdata;
    logic [0:0] awid, arid;
    logic [AW-1:0] awaddr, araddr;
    logic [7:0] awlen, arlen;
    logic [2:0] awsize, arsize, awprot, arprot;
    logic [1:0] awburst, arburst;
    logic awlock, arlock, awvalid, arvalid;
    logic [3:0] awcache, arcache, awqos, arqos;
    logic awready, wready, arready;
    logic [DW-1:0] wdata;
    logic [3:0] wstrb;
    logic wlast, wvalid, bready, rready;
    logic [1:0] bresp, rresp;
    logic bvalid, rvalid, rlast;
    logic [DW-1:0] rdata;
    logic [1:0] fsm_state;

    iob2axi_burst #(.ADDR_W(AW), .DATA_W(DW), .AXI_ID_W(1), .AXI_LEN_W(8)) dut (
        .clk(clk), .rst(rst), .run(run), .direction(direction), .length(length),
        .ready(ready), .error(error), .s_valid(s_valid), .s_addr(s_addr),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_rdata(s_rdata), .s_ready(s_ready),
        .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
        .m_axi_awburst(awburst), .m_axi_awlock(awlock), .m_axi_awcache(awcache),
        .m_axi_awprot(awprot), .m_axi_awqos(awqos), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast), .m_axi_wvalid(wvalid),
        .m_axi_wready(wready), .m_axi_bid(1'b0), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid),
        .m_axi_bready(bready), .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen),
        .m_axi_arsize(arsize), .m_axi_arburst(arburst), .m_axi_arlock(arlock),
        .m_axi_arcache(arcache), .m_axi_arprot(arprot), .m_axi_arqos(arqos),
        .m_axi_arvalid(arvalid), .m_axi_arready(arready), .m_axi_rid(1'b0), .m_axi_rdata(rdata),
        .m_axi_rresp(rresp), .m_axi_rlast(rlast), .m_axi_rvalid(rvalid), .m_axi_rready(rready),
        .fsm_state(fsm_state)
    );

    // AXI RAM slave model
    logic [DW-1:0] mem [0:8191];
    logic [12:0] wptr, rptr;
    logic [8:0] r_rem;
    logic force_slverr = 1'b0;

    initial for (int i = 0; i < 8192; i++) mem[i] = '0;

    always @(posedge clk) begin
        if (!rst) begin
            awready <= 1'b0; wready <= 1'b0; arready <= 1'b0;
            bvalid <= 1'b0; bresp <= 2'b00;
            rvalid <= 1'b0; rlast <= 1'b0; rresp <= 2'b00; rdata <= '0;
            r_rem <= '0; wptr <= '0; rptr <= '0;
        end else begin
            awready <= ($urandom_range(0, 3) != 0);
            wready  <= ($urandom_range(0, 3) != 0);
            arready <= ($urandom_range(0, 3) != 0);
            if (awvalid && awready) wptr <= awaddr[14:2];
            if (wvalid && wready) begin
                for (int b = 0; b < 4; b++)
                    if (wstrb[b]) mem[wptr][b*8 +: 8] <= wdata[b*8 +: 8];
                wptr <= wptr + 1'b1;
            end
            if (wvalid && wready && wlast) begin
                bvalid <= 1'b1;
                bresp  <= force_slverr ? 2'b10 : 2'b00;
            end else if (bvalid && bready) begin
                bvalid <= 1'b0;
            end
            if (arvalid && arready) begin
                rptr  <= araddr[14:2];
                r_rem <= 9'(arlen) + 9'd1;
            end
            if (!rvalid || rready) begin
                if (r_rem != 0 && $urandom_range(0, 3) != 0) begin
                    rvalid <= 1'b1;
                    rdata  <= mem[rptr];
                    rlast  <= (r_rem == 9'd1);
                    rresp  <= force_slverr ? 2'b10 : 2'b00;
                    rptr   <= rptr + 1'b1;
                    r_rem  <= r_rem - 1'b1;
                end else begin
                    rvalid <= 1'b0;
                end
            end
        end
    end

    // Scoreboard
    int vec_cnt = 0;
    int err_cnt = 0;
    int pulse_cnt = 0;
    int wlast_cnt = 0;
    logic cur_dir = 1'b0;
    logic [31:0] exp_aw_q[$];
    logic [31:0] exp_ar_q[$];
    logic [36:0] exp_w_q[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] wdat [0:255];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic note_fail(input string name);
        vec_cnt++;
        err_cnt++;
        $display("FAIL %s: got event expected none", name);
    endtask

    localparam logic [19:0] ATTR = {1'b0, 3'd2, 2'b01, 1'b0, 4'b0011, 3'b010, 4'b0000};

    always @(negedge clk) begin
        if (rst) begin
            if (awvalid && awready) begin
                if (exp_aw_q.size() == 0) note_fail("aw_unexpected");
                else chk("aw_addr_len", {awaddr, awlen}, exp_aw_q.pop_front());
                chk("aw_attr", {awid, awsize, awburst, awlock, awcache, awprot, awqos}, ATTR);
            end
            if (arvalid && arready) begin
                if (exp_ar_q.size() == 0) note_fail("ar_unexpected");
                else chk("ar_addr_len", {araddr, arlen}, exp_ar_q.pop_front());
                chk("ar_attr", {arid, arsize, arburst, arlock, arcache, arprot, arqos}, ATTR);
            end
            if (wvalid && wready) begin
                if (exp_w_q.size() == 0) note_fail("w_unexpected");
                else chk("w_beat", {wlast, wstrb, wdata}, exp_w_q.pop_front());
                if (wlast) wlast_cnt++;
            end
            if (s_ready) begin
                pulse_cnt++;
                if (!cur_dir) begin
                    if (exp_q.size() == 0) note_fail("rdata_unexpected");
                    else chk("s_rdata", s_rdata, exp_q.pop_front());
                end
            end
        end
    end

    // Driver tasks: inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 2000) begin
            tick();
            n++;
        end
        chk("ready_return", ready, 1);
    endtask

    task automatic start(input logic dir, input logic [7:0] len, input logic [AW-1:0] addr);
        run = 1'b1; direction = dir; length = len; s_addr = addr; cur_dir = dir;
        if (dir) exp_aw_q.push_back({addr, len});
        else     exp_ar_q.push_back({addr, len});
        tick();
        run = 1'b0;
        chk("ready_low", ready, 0);
        chk("error_cleared", error, 0);
    endtask

    task automatic beat(input logic [DW-1:0] d);
        int n = 0;
        logic got = 1'b0;
        s_valid = 1'b1; s_wdata = d; s_wstrb = 4'hF;
        while (!got && n < 2000) begin
            @(negedge clk);
            got = s_ready;
            n++;
        end
        if (!got) note_fail("beat_timeout");
        tick();
    endtask

    task automatic write_burst(input logic [AW-1:0] addr, input int len, input logic busy_run);
        int p0 = pulse_cnt;
        int w0 = wlast_cnt;
        start(1'b1, 8'(len), addr);
        if (busy_run) begin
            run = 1'b1; direction = 1'b0;
            tick();
            run = 1'b0;
        end
        for (int i = 0; i <= len; i++) begin
            exp_w_q.push_back({(i == len), 4'hF, wdat[i]});
            beat(wdat[i]);
        end
        s_valid = 1'b0;
        wait_ready();
        chk("w_s_ready_pulses", 64'(pulse_cnt - p0), 64'(len + 1));
        chk("wlast_count", 64'(wlast_cnt - w0), 1);
        chk("w_queue_drained", 64'(exp_w_q.size()), 0);
        for (int i = 0; i <= len; i++) chk("ram_word", mem[int'(addr[14:2]) + i], wdat[i]);
    endtask

    task automatic read_burst(input logic [AW-1:0] addr, input int len);
        int p0 = pulse_cnt;
        for (int i = 0; i <= len; i++) exp_q.push_back(wdat[i]);
        start(1'b0, 8'(len), addr);
        for (int i = 0; i <= len; i++) beat('0);
        s_valid = 1'b0;
        wait_ready();
        chk("r_s_ready_pulses", 64'(pulse_cnt - p0), 64'(len + 1));
        chk("r_queue_drained", 64'(exp_q.size()), 0);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        chk("rst_ready", ready, 1);
        chk("rst_error", error, 0);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_s_rdata", s_rdata, 0);
        chk("rst_valids", {awvalid, wvalid, arvalid, bready, rready}, 0);
        rst = 1'b1;
        tick();

        // s_valid while idle is ignored
        s_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_s_ready", s_ready, 0);
        end
        s_valid = 1'b0;

        // 1: single-beat write
        wdat[0] = 32'd1;
        write_burst(24'h0, 0, 1'b0);
        chk("t1_error", error, 0);

        // 2: three-beat write at 12, with a run pulse while busy
        wdat[0] = 32'd4; wdat[1] = 32'd5; wdat[2] = 32'd6;
        write_burst(24'd12, 2, 1'b1);

        // 3: single-beat read at 0
        wdat[0] = 32'd1;
        read_burst(24'h0, 0);

        // 4: three-beat read at 12
        wdat[0] = 32'd4; wdat[1] = 32'd5; wdat[2] = 32'd6;
        read_burst(24'd12, 2);
        chk("t4_error", error, 0);

        // 5: 256-beat write then read back
        for (int i = 0; i < 256; i++) wdat[i] = 32'(32 + i);
        write_burst(24'h4000, 255, 1'b0);
        read_burst(24'h4000, 255);
        chk("t5_error", error, 0);

        // 6: mid-burst reset
        wdat[0] = 32'hA5A5_0001;
        start(1'b1, 8'd3, 24'h100);
        exp_w_q.push_back({1'b0, 4'hF, wdat[0]});
        beat(wdat[0]);
        rst = 1'b0;
        s_valid = 1'b0;
        tick();
        chk("t6_ready", ready, 1);
        chk("t6_valids", {awvalid, wvalid, arvalid}, 0);
        chk("t6_s_ready", s_ready, 0);
        exp_w_q.delete();
        exp_aw_q.delete();
        rst = 1'b1;
        tick();

        // 6b: SLVERR on write response holds until next run
        force_slverr = 1'b1;
        wdat[0] = 32'hDEAD_BEEF;
        write_burst(24'h200, 0, 1'b0);
        chk("slverr_write", error, 1);
        repeat (5) tick();
        chk("slverr_hold", error, 1);
        force_slverr = 1'b0;
        read_burst(24'h200, 0);
        chk("ok_read_error", error, 0);

        // 6c: SLVERR on a read beat
        force_slverr = 1'b1;
        wdat[0] = 32'd4; wdat[1] = 32'd5;
        read_burst(24'd12, 1);
        chk("slverr_read", error, 1);
        force_slverr = 1'b0;

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
